// File: rtl/ifu_prefetch.sv
// ifu_prefetch: byte-queue instruction prefetcher for the IJVM datapath.
// Refills a circular byte queue one word at a time and presents MBR1/MBR2.
module ifu_prefetch #(
   parameter int WORD_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int QUEUE_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  fetch_req,
   output logic [ADDR_WIDTH-1:0] fetch_addr,
   input  logic                  fetch_ack,
   input  logic [WORD_WIDTH-1:0] fetch_data,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   input  logic                  consume1,
   input  logic                  consume2,
   output logic [7:0]            mbr1,
   output logic [15:0]           mbr2,
   output logic                  mbr1_valid,
   output logic                  mbr2_valid,
   output logic [ADDR_WIDTH-1:0] pc
);
   localparam int BPW = WORD_WIDTH / 8;
   localparam int PW  = $clog2(QUEUE_DEPTH);
   localparam int PW1 = PW + 1;
   localparam int CW  = $clog2(QUEUE_DEPTH + 1);
   localparam int SW  = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(BPW - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_req;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH-1:0] r_fptr;
   logic [ADDR_WIDTH-1:0] r_pc;
   logic [SW-1:0]         r_skip;
   logic [CW-1:0]         r_count;
   logic [PW-1:0]         r_head;
   logic [PW-1:0]         r_tail;
   logic [7:0]            r_q [QUEUE_DEPTH];

   logic                  w_issue;
   logic                  w_push;
   logic [1:0]            w_pop_n;
   logic [CW-1:0]         w_push_n;
   logic [CW-1:0]         w_push_cnt;
   logic [PW-1:0]         w_head1;
   logic [PW-1:0]         w_head_nxt;
   logic [PW-1:0]         w_tail_nxt;
   logic [PW-1:0]         w_widx [BPW];
   logic [7:0]            w_wbyte [BPW];
   logic [WORD_WIDTH-1:0] w_shift;

   // Pointer arithmetic modulo a depth that need not be a power of two.
   function automatic logic [PW-1:0] wrap(input logic [PW:0] v);
      if (v >= PW1'(QUEUE_DEPTH)) return PW'(v - PW1'(QUEUE_DEPTH));
      return PW'(v);
   endfunction

   always_comb begin
      w_pop_n = 2'd0;
      priority case (1'b1)
         consume2: if (r_count >= CW'(2)) w_pop_n = 2'd2;
         consume1: if (r_count >= CW'(1)) w_pop_n = 2'd1;
         default:  w_pop_n = 2'd0;
      endcase
      if (redirect) w_pop_n = 2'd0;
   end

   // An ack coinciding with a redirect retires the request, so no DROP.
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (!redirect &&
                (CW'(QUEUE_DEPTH) - r_count) >= CW'(BPW)) begin
               w_state_nxt = S_WAIT;
               w_issue     = 1'b1;
            end
         end
         S_WAIT: begin
            if (fetch_ack)     w_state_nxt = S_IDLE;
            else if (redirect) w_state_nxt = S_DROP;
         end
         S_DROP: begin
            if (fetch_ack) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_push     = (r_state == S_WAIT) && fetch_ack && !redirect;
   assign w_push_n   = CW'(BPW) - CW'(r_skip);
   assign w_push_cnt = w_push ? w_push_n : '0;

   always_comb begin
      w_shift    = fetch_data << {r_skip, 3'b000};
      w_head1    = wrap({1'b0, r_head} + PW1'(1));
      w_head_nxt = wrap({1'b0, r_head} + PW1'(w_pop_n));
      w_tail_nxt = wrap({1'b0, r_tail} + PW1'(w_push_cnt));
      for (int k = 0; k < BPW; k++) begin
         w_widx[k]  = wrap({1'b0, r_tail} + PW1'(k));
         w_wbyte[k] = w_shift[WORD_WIDTH-1-8*k -: 8];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_req   <= 1'b0;
         r_addr  <= '0;
         r_fptr  <= '0;
         r_skip  <= '0;
         r_pc    <= '0;
         r_count <= '0;
         r_head  <= '0;
         r_tail  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_req   <= (w_state_nxt != S_IDLE);
         if (w_issue) r_addr <= r_fptr;
         if (redirect) begin
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_fptr  <= redirect_pc & ~LOW_MASK;
            r_skip  <= SW'(redirect_pc & LOW_MASK);
            r_pc    <= redirect_pc;
         end else begin
            r_count <= r_count + w_push_cnt - CW'(w_pop_n);
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_pc    <= r_pc + ADDR_WIDTH'(w_pop_n);
            if (w_push) begin
               r_fptr <= r_fptr + ADDR_WIDTH'(BPW);
               r_skip <= '0;
            end
         end
      end
   end

   // Leading bytes dropped by skip never reach the queue.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < QUEUE_DEPTH; i++) r_q[i] <= '0;
      end else if (w_push) begin
         for (int k = 0; k < BPW; k++) begin
            if (CW'(k) < w_push_n) r_q[w_widx[k]] <= w_wbyte[k];
         end
      end
   end

   assign fetch_req  = r_req;
   assign fetch_addr = r_addr;
   assign pc         = r_pc;
   assign mbr1       = r_q[r_head];
   assign mbr2       = {r_q[r_head], r_q[w_head1]};
   assign mbr1_valid = (r_count != '0);
   assign mbr2_valid = (r_count >= CW'(2));

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: vector table, directed corner sequences and a random
// run checked against a byte-queue reference model.
module tb_ifu_prefetch;
   localparam int BPW   = 4;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_ack = 1'b0;
   logic [31:0] fetch_data = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        consume1 = 1'b0;
   logic        consume2 = 1'b0;
   logic [7:0]  mbr1;
   logic [15:0] mbr2;
   logic        mbr1_valid;
   logic        mbr2_valid;
   logic [31:0] pc;

   ifu_prefetch #(
      .WORD_WIDTH (32),
      .ADDR_WIDTH (32),
      .QUEUE_DEPTH(DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .fetch_req  (fetch_req),
      .fetch_addr (fetch_addr),
      .fetch_ack  (fetch_ack),
      .fetch_data (fetch_data),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .consume1   (consume1),
      .consume2   (consume2),
      .mbr1       (mbr1),
      .mbr2       (mbr2),
      .mbr1_valid (mbr1_valid),
      .mbr2_valid (mbr2_valid),
      .pc         (pc)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int ack_pct = 0;
   bit spurious = 0;

   logic [7:0] mem [256];

   logic [7:0]  mq [$];
   logic [31:0] m_pc;
   logic [31:0] m_fptr;
   logic [31:0] m_raddr;
   int          m_skip;
   bit          m_out;
   bit          m_drop;

   typedef struct {
      bit          mem_on;
      bit          c1;
      bit          c2;
      bit          req;
      logic [31:0] addr;
      bit          v1;
      bit          v2;
      logic [7:0]  m1;
      logic [15:0] m2;
      logic [31:0] pc;
   } vec_t;

   vec_t tbl [12];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [7:0] b;
      b = a[7:0];
      return {mem[b], mem[b + 8'd1], mem[b + 8'd2], mem[b + 8'd3]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      mq.delete();
      m_pc    = '0;
      m_fptr  = '0;
      m_raddr = '0;
      m_skip  = 0;
      m_out   = 0;
      m_drop  = 0;
   endfunction

   function automatic void model_step(input bit rd, input logic [31:0] rpc,
                                      input bit c1, input bit c2,
                                      input bit ack, input logic [31:0] d);
      int pre;
      int n;
      pre = mq.size();
      if (rd) begin
         mq.delete();
         m_pc   = rpc;
         m_skip = int'(rpc[1:0]);
         m_fptr = {rpc[31:2], 2'b00};
         if (m_out && !ack) m_drop = 1;
         else begin
            m_out  = 0;
            m_drop = 0;
         end
         return;
      end
      n = c2 ? 2 : (c1 ? 1 : 0);
      if (pre >= n) begin
         repeat (n) void'(mq.pop_front());
         m_pc = m_pc + 32'(n);
      end
      if (m_out) begin
         if (ack) begin
            if (!m_drop) begin
               for (int i = m_skip; i < BPW; i++) mq.push_back(d[31-8*i -: 8]);
               m_fptr = m_fptr + 32'(BPW);
               m_skip = 0;
            end
            m_out  = 0;
            m_drop = 0;
         end
      end else if (DEPTH - pre >= BPW) begin
         m_out   = 1;
         m_raddr = m_fptr;
      end
   endfunction

   task automatic cycle();
      if (ack_pct > 0) begin
         fetch_ack = 1'b0;
         if (fetch_req && $urandom_range(1, 100) <= ack_pct) begin
            fetch_ack  = 1'b1;
            fetch_data = mem_word(fetch_addr);
         end else if (!fetch_req && spurious && $urandom_range(1, 100) <= 5) begin
            fetch_ack  = 1'b1;
            fetch_data = $urandom;
         end
      end
      @(posedge clk);
      model_step(redirect, redirect_pc, consume1, consume2, fetch_ack, fetch_data);
      #1;
      redirect  = 1'b0;
      consume1  = 1'b0;
      consume2  = 1'b0;
      fetch_ack = 1'b0;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".req"}, 32'(fetch_req), 32'(m_out));
      if (m_out) chk({tag, ".addr"}, fetch_addr, m_raddr);
      chk({tag, ".v1"}, 32'(mbr1_valid), 32'(mq.size() >= 1));
      chk({tag, ".v2"}, 32'(mbr2_valid), 32'(mq.size() >= 2));
      chk({tag, ".pc"}, pc, m_pc);
      if (mq.size() >= 1) chk({tag, ".mbr1"}, 32'(mbr1), 32'(mq[0]));
      if (mq.size() >= 2) chk({tag, ".mbr2"}, 32'(mbr2), 32'({mq[0], mq[1]}));
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      ack_pct   = 0;
      spurious  = 0;
      redirect  = 1'b0;
      consume1  = 1'b0;
      consume2  = 1'b0;
      fetch_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      chk("rst.req", 32'(fetch_req), 32'h0);
      chk("rst.addr", fetch_addr, 32'h0);
      chk("rst.pc", pc, 32'h0);
      chk("rst.mbr1", 32'(mbr1), 32'h0);
      chk("rst.mbr2", 32'(mbr2), 32'h0);
      chk("rst.v1", 32'(mbr1_valid), 32'h0);
      chk("rst.v2", 32'(mbr2_valid), 32'h0);
      reset = 1'b1;
   endtask

   initial begin
      for (int a = 0; a < 256; a++) mem[a] = 8'((a + 1) * 16);

      tbl[0]  = '{1, 0, 0, 1, 32'h0, 0, 0, 8'h00, 16'h0000, 32'd0};
      tbl[1]  = '{1, 0, 0, 0, 32'h0, 1, 1, 8'h10, 16'h1020, 32'd0};
      tbl[2]  = '{0, 1, 0, 1, 32'h4, 1, 1, 8'h20, 16'h2030, 32'd1};
      tbl[3]  = '{0, 0, 1, 1, 32'h4, 1, 0, 8'h40, 16'h0000, 32'd3};
      tbl[4]  = '{0, 1, 0, 1, 32'h4, 0, 0, 8'h00, 16'h0000, 32'd4};
      tbl[5]  = '{0, 0, 1, 1, 32'h4, 0, 0, 8'h00, 16'h0000, 32'd4};
      tbl[6]  = '{1, 0, 0, 0, 32'h4, 1, 1, 8'h50, 16'h5060, 32'd4};
      tbl[7]  = '{1, 1, 0, 1, 32'h8, 1, 1, 8'h60, 16'h6070, 32'd5};
      tbl[8]  = '{1, 0, 1, 0, 32'h8, 1, 1, 8'h80, 16'h8090, 32'd7};
      tbl[9]  = '{1, 0, 0, 0, 32'h8, 1, 1, 8'h80, 16'h8090, 32'd7};
      tbl[10] = '{1, 1, 0, 0, 32'h8, 1, 1, 8'h90, 16'h90A0, 32'd8};
      tbl[11] = '{1, 0, 0, 1, 32'hC, 1, 1, 8'h90, 16'h90A0, 32'd8};

      // Cold start and consume sequence
      do_reset();
      for (int i = 0; i < 12; i++) begin
         ack_pct  = tbl[i].mem_on ? 100 : 0;
         consume1 = tbl[i].c1;
         consume2 = tbl[i].c2;
         cycle();
         chk($sformatf("tbl%0d.req", i), 32'(fetch_req), 32'(tbl[i].req));
         if (tbl[i].req) chk($sformatf("tbl%0d.addr", i), fetch_addr, tbl[i].addr);
         chk($sformatf("tbl%0d.v1", i), 32'(mbr1_valid), 32'(tbl[i].v1));
         chk($sformatf("tbl%0d.v2", i), 32'(mbr2_valid), 32'(tbl[i].v2));
         chk($sformatf("tbl%0d.pc", i), pc, tbl[i].pc);
         if (tbl[i].v1) chk($sformatf("tbl%0d.mbr1", i), 32'(mbr1), 32'(tbl[i].m1));
         if (tbl[i].v2) chk($sformatf("tbl%0d.mbr2", i), 32'(mbr2), 32'(tbl[i].m2));
      end

      // Redirect to an unaligned PC while idle
      do_reset();
      mem[4] = 8'hAA; mem[5] = 8'hBB; mem[6] = 8'hCC; mem[7] = 8'hDD;
      redirect = 1'b1; redirect_pc = 32'h6;
      cycle();
      chk("rdi.req", 32'(fetch_req), 32'h0);
      chk("rdi.pc", pc, 32'h6);
      ack_pct = 100;
      cycle();
      chk("rdi.addr", fetch_addr, 32'h4);
      cycle();
      chk("rdi.mbr1", 32'(mbr1), 32'hCC);
      chk("rdi.mbr2", 32'(mbr2), 32'hCCDD);
      chk("rdi.v2", 32'(mbr2_valid), 32'h1);
      consume1 = 1'b1;
      cycle();
      chk("rdi.mbr1b", 32'(mbr1), 32'hDD);
      chk("rdi.v2b", 32'(mbr2_valid), 32'h0);
      check_model("rdi");

      // Redirect while waiting: stale word must be dropped
      do_reset();
      cycle();
      chk("rdw.req0", 32'(fetch_req), 32'h1);
      redirect = 1'b1; redirect_pc = 32'h20;
      cycle();
      chk("rdw.req1", 32'(fetch_req), 32'h1);
      chk("rdw.addr1", fetch_addr, 32'h0);
      chk("rdw.pc", pc, 32'h20);
      cycle();
      fetch_ack = 1'b1; fetch_data = 32'hDEADBEEF;
      cycle();
      chk("rdw.req2", 32'(fetch_req), 32'h0);
      chk("rdw.v1", 32'(mbr1_valid), 32'h0);
      cycle();
      chk("rdw.req3", 32'(fetch_req), 32'h1);
      chk("rdw.addr3", fetch_addr, 32'h20);
      fetch_ack = 1'b1; fetch_data = 32'h11223344;
      cycle();
      chk("rdw.mbr2", 32'(mbr2), 32'h1122);
      check_model("rdw");

      // Fill to full, then free space two bytes at a time
      do_reset();
      ack_pct = 100;
      repeat (6) cycle();
      chk("full.req", 32'(fetch_req), 32'h0);
      check_model("full");
      consume2 = 1'b1;
      cycle();
      repeat (2) begin
         cycle();
         chk("full6.req", 32'(fetch_req), 32'h0);
      end
      consume2 = 1'b1;
      cycle();
      chk("full4.req", 32'(fetch_req), 32'h0);
      cycle();
      chk("full4.req2", 32'(fetch_req), 32'h1);
      chk("full4.addr", fetch_addr, 32'h8);

      // Under-run consume and ack with simultaneous consume
      do_reset();
      redirect = 1'b1; redirect_pc = 32'h1;
      cycle();
      cycle();
      fetch_ack = 1'b1; fetch_data = 32'h01020304;
      cycle();
      chk("cnt.mbr1", 32'(mbr1), 32'h02);
      cycle();
      chk("cnt.addr", fetch_addr, 32'h4);
      fetch_ack = 1'b1; fetch_data = 32'h05060708; consume1 = 1'b1;
      cycle();
      chk("cnt.mbr2", 32'(mbr2), 32'h0304);
      consume2 = 1'b1;
      cycle();
      chk("cnt6.req", 32'(fetch_req), 32'h0);
      consume2 = 1'b1;
      cycle();
      consume1 = 1'b1;
      cycle();
      consume2 = 1'b1;
      cycle();
      chk("cnt1.pc", pc, 32'h7);
      chk("cnt1.mbr1", 32'(mbr1), 32'h08);
      chk("cnt1.v1", 32'(mbr1_valid), 32'h1);
      consume1 = 1'b1;
      cycle();
      chk("cnt0.v1", 32'(mbr1_valid), 32'h0);
      check_model("cnt");

      // Reset during an outstanding request, then a stray ack
      do_reset();
      cycle();
      #2 reset = 1'b0;
      #1;
      chk("arst.req", 32'(fetch_req), 32'h0);
      chk("arst.pc", pc, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
      fetch_ack = 1'b1; fetch_data = 32'hCAFEBABE;
      cycle();
      chk("arst.v1", 32'(mbr1_valid), 32'h0);
      chk("arst.req2", 32'(fetch_req), 32'h1);
      ack_pct = 100;
      cycle();
      check_model("arst");

      // Randomized traffic against the reference model
      do_reset();
      ack_pct  = 40;
      spurious = 1;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 99) < 3) begin
            redirect = 1'b1;
            if ($urandom_range(0, 3) == 0)
               redirect_pc = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            else
               redirect_pc = 32'($urandom_range(0, 255));
         end
         consume1 = ($urandom_range(0, 99) < 35);
         consume2 = ($urandom_range(0, 99) < 35);
         cycle();
         check_model("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifu_prefetch.md
# ifu_prefetch

Parametrised instruction fetch unit for the next-generation IJVM datapath. It replaces the single-byte MBR/PC fetch path with a byte queue that prefetches instruction-stream words from memory ahead of the microprogram. Opcode and operand bytes are presented to the datapath as MBR1 (next byte) and MBR2 (next two bytes), and the datapath consumes them with per-cycle strobes. It sits between the word-wide memory port and the MBR/PC-side B-bus drivers, and supports PC redirects for branches and invokes.

## Interface
Parameters:
- WORD_WIDTH, 32, memory word width in bits; must be a multiple of 8. BPW = WORD_WIDTH/8.
- ADDR_WIDTH, 32, byte-address width.
- QUEUE_DEPTH, 8, byte capacity of the prefetch queue; must be a multiple of BPW and at least 2*BPW.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- fetch_req  output  1  word-fetch request; registered.
- fetch_addr  output  ADDR_WIDTH  byte address of the requested word; always BPW-aligned.
- fetch_ack  input  1  memory returns fetch_data this cycle.
- fetch_data  input  WORD_WIDTH  fetched word; big-endian, so the lowest-address byte is in the MSBs.
- redirect  input  1  load a new PC and flush the queue.
- redirect_pc  input  ADDR_WIDTH  new byte PC.
- consume1  input  1  pop 1 byte.
- consume2  input  1  pop 2 bytes.
- mbr1  output  8  head byte.
- mbr2  output  16  {head, head+1}.
- mbr1_valid  output  1  count >= 1.
- mbr2_valid  output  1  count >= 2.
- pc  output  ADDR_WIDTH  byte address of the queue head.

## Operation
- The queue is circular, holding QUEUE_DEPTH bytes, with head and tail pointers and a count in the range 0..QUEUE_DEPTH.
- Fetch pointer (fptr) is the word-aligned address of the next word to request; fetch_addr = fptr.
- skip, in the range 0..BPW-1, is the number of leading bytes of the next returned word to drop.
- FSM states:
  - IDLE: no request outstanding. Go to WAIT and assert fetch_req when (QUEUE_DEPTH − count) >= BPW and no redirect is occurring this cycle.
  - WAIT: request outstanding, fetch_req held high. On fetch_ack, push BPW − skip bytes in address order, clear skip, advance fptr by BPW, then go to IDLE.
  - DROP: request outstanding, but a redirect occurred after issue. On fetch_ack, discard the data, leave fptr unchanged, then go to IDLE.
- Only one request is outstanding at a time.
- fetch_req and fetch_addr are stable from issue until fetch_ack.
- Space accounting counts the bytes of the outstanding word as reserved. The issue condition is therefore checked against (count + reserved).
- Redirect:
  - count is set to 0.
  - fptr is set to redirect_pc with the low bits cleared; skip is set to the low bits of redirect_pc; pc is set to redirect_pc.
  - In WAIT, the state goes to DROP. In DROP or IDLE, the state goes to IDLE.
  - Redirect has priority over fetch_ack, consume1 and consume2 in the same cycle.
- Consume:
  - consume2 takes precedence if both strobes are high.
  - A pop of n bytes advances head and pc by n.
  - A consume with fewer than n valid bytes is ignored: no pointer, count or pc change. The microprogram must stall on the valid flag.
- A simultaneous push and pop gives count_next = count + pushed − popped, and is never capped.
- mbr1 and mbr2 are combinational reads of head and head+1 (mod QUEUE_DEPTH). They are don't-care when not valid, and are driven 0 after reset.
- pc is byte-granular and wraps modulo 2^ADDR_WIDTH; fptr wraps the same way.

## Timing
- Reset values: state IDLE, fetch_req 0, fetch_addr 0, pc 0, count 0, skip 0, mbr1 0, mbr2 0, mbr1_valid 0, mbr2_valid 0.
- First request: fetch_req rises after the first clk edge following reset deassertion.
- Fill latency: with fetch_ack at edge N, mbr1_valid and mbr2_valid are high after edge N, i.e. the cycle following the ack.
- Back-to-back fetch: after an ack at edge N, the next fetch_req is high after edge N+1. There is one IDLE cycle between requests, which gives a sustained rate of one word per 2 cycles minimum.
- Redirect at edge N: valid flags are 0 after edge N. A new request is issued after edge N+1 from IDLE, or after the drop-ack cycle from DROP.
- Reset asserted mid-request clears all state immediately. A subsequent fetch_ack while in IDLE is ignored.

## Test plan
- Cold start, WORD_WIDTH=32, QUEUE_DEPTH=8, memory returns 0x10203040 at address 0 with a 1-cycle ack: mbr1=0x10, mbr2=0x1020, pc=0. A second request issues to fetch_addr=4.
- Consume sequence consume1, then consume2, then consume1 over a 4-byte queue: pc steps 1, 3, 4. mbr1 shows 0x20 then 0x40. count reaches 0 and valid drops.
- Redirect to 0x00000006 while idle, memory returns 0xAABBCCDD from address 4: only 0xCC and 0xDD are queued, mbr2=0xCCDD, pc=6.
- Redirect while WAIT, with the old ack returning 0xDEADBEEF two cycles later: the data is dropped, no byte of 0xDEADBEEF is ever visible, and the next request goes to the redirect word address.
- Fill to full (count=8) with consumers idle: fetch_req stays 0. One consume2 makes count 6 with 2 bytes free, still below BPW, so there is no request. A second consume2 frees 4 bytes and the request issues.
- consume2 with count=1, and a simultaneous ack+consume1 at count=3: the first is ignored with count still 1. For the second, count_next = 3+4−1 = 6.
